// File: rtl/mips_defs.sv
// Shared MIPS encoding constants and instruction-kind decode for the hazard logic.
package mips_defs;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    // Tuse/Tnew encoding: 0..2 are cycle counts, T_NONE means "not used / not produced"
    localparam logic [1:0] T_NONE = 2'b11;

    typedef enum logic [3:0] {
        K_NONE,
        K_ALU_R,
        K_MULT,
        K_DIV,
        K_MF,
        K_MT,
        K_JR,
        K_ORI,
        K_LUI,
        K_LW,
        K_SW,
        K_BEQ,
        K_JAL
    } ikind_t;

    // Map a raw instruction word to the kind that drives all timing attributes
    function automatic ikind_t decode_kind(input logic [31:0] ir);
        ikind_t k;
        k = K_NONE;
        case (ir[31:26])
            OP_RTYPE: begin
                case (ir[5:0])
                    FN_ADDU, FN_SUBU:  k = K_ALU_R;
                    FN_MULT, FN_MULTU: k = K_MULT;
                    FN_DIV, FN_DIVU:   k = K_DIV;
                    FN_MFHI, FN_MFLO:  k = K_MF;
                    FN_MTHI, FN_MTLO:  k = K_MT;
                    FN_JR:             k = K_JR;
                    default:           k = K_NONE;
                endcase
            end
            OP_LW:   k = K_LW;
            OP_SW:   k = K_SW;
            OP_BEQ:  k = K_BEQ;
            OP_ORI:  k = K_ORI;
            OP_LUI:  k = K_LUI;
            OP_JAL:  k = K_JAL;
            default: k = K_NONE;
        endcase
        return k;
    endfunction

    // Tnew one stage later: a result needed N cycles after EX is needed N-1 cycles after MEM
    function automatic logic [1:0] t_age(input logic [1:0] t);
        logic [1:0] r;
        if (t == T_NONE)
            r = T_NONE;
        else if (t == 2'd0)
            r = 2'd0;
        else
            r = t - 2'd1;
        return r;
    endfunction

endpackage

// File: rtl/instr_class.sv
// Combinational classification of one instruction: operand fields and pipeline timing.
module instr_class
    import mips_defs::*;
(
    input  logic [31:0] ir,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  dst,
    output logic [1:0]  tuse_rs,
    output logic [1:0]  tuse_rt,
    output logic [1:0]  tnew,
    output logic        is_md,
    output logic        is_mult,
    output logic        is_div,
    output logic        is_hilo
);

    ikind_t kind;
    logic   unused_shamt;

    assign rs           = ir[25:21];
    assign rt           = ir[20:16];
    assign unused_shamt = ^ir[10:6];

    // Per-kind source timing, destination and result availability
    always_comb begin
        kind    = decode_kind(ir);
        dst     = 5'd0;
        tuse_rs = T_NONE;
        tuse_rt = T_NONE;
        tnew    = T_NONE;
        is_md   = 1'b0;
        is_mult = 1'b0;
        is_div  = 1'b0;
        is_hilo = 1'b0;
        case (kind)
            K_ALU_R: begin
                tuse_rs = 2'd1;
                tuse_rt = 2'd1;
                dst     = ir[15:11];
                tnew    = 2'd1;
            end
            K_MULT: begin
                tuse_rs = 2'd1;
                tuse_rt = 2'd1;
                is_md   = 1'b1;
                is_mult = 1'b1;
                is_hilo = 1'b1;
            end
            K_DIV: begin
                tuse_rs = 2'd1;
                tuse_rt = 2'd1;
                is_md   = 1'b1;
                is_div  = 1'b1;
                is_hilo = 1'b1;
            end
            K_MF: begin
                dst     = ir[15:11];
                tnew    = 2'd1;
                is_hilo = 1'b1;
            end
            K_MT: begin
                tuse_rs = 2'd1;
                is_hilo = 1'b1;
            end
            K_JR: begin
                tuse_rs = 2'd0;
            end
            K_ORI: begin
                tuse_rs = 2'd1;
                dst     = ir[20:16];
                tnew    = 2'd1;
            end
            K_LUI: begin
                dst     = ir[20:16];
                tnew    = 2'd1;
            end
            K_LW: begin
                tuse_rs = 2'd1;
                dst     = ir[20:16];
                tnew    = 2'd2;
            end
            K_SW: begin
                tuse_rs = 2'd1;
                tuse_rt = 2'd2;
            end
            K_BEQ: begin
                tuse_rs = 2'd0;
                tuse_rt = 2'd0;
            end
            K_JAL: begin
                dst     = 5'd31;
                tnew    = 2'd0;
            end
            default: begin
                dst     = 5'd0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Front-end freeze control: data hazards, mult/div busy tracking and stall statistics.
module hazard_stall_ctrl
    import mips_defs::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [31:0]      IR_D,
    input  logic [31:0]      IR_EX,
    input  logic [31:0]      IR_MEM,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_clr,
    output logic             md_start,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned MD_W   = (MD_MAX < 2) ? 1 : $clog2(MD_MAX + 1);

    logic [4:0] rs_d, rt_d, dst_d, rs_ex, rt_ex, dst_ex, rs_m, rt_m, dst_m;
    logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
    logic [1:0] tuse_rs_ex, tuse_rt_ex, tnew_ex;
    logic [1:0] tuse_rs_m, tuse_rt_m, tnew_m, tnew_mem;
    logic       is_md_d, is_mult_d, is_div_d, is_hilo_d;
    logic       is_md_ex, is_mult_ex, is_div_ex, is_hilo_ex;
    logic       is_md_m, is_mult_m, is_div_m, is_hilo_m;

    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             data_stall, md_stall, stall;
    logic             unused_fields;

    instr_class u_cls_d (
        .ir      (IR_D),
        .rs      (rs_d),
        .rt      (rt_d),
        .dst     (dst_d),
        .tuse_rs (tuse_rs_d),
        .tuse_rt (tuse_rt_d),
        .tnew    (tnew_d),
        .is_md   (is_md_d),
        .is_mult (is_mult_d),
        .is_div  (is_div_d),
        .is_hilo (is_hilo_d)
    );

    instr_class u_cls_ex (
        .ir      (IR_EX),
        .rs      (rs_ex),
        .rt      (rt_ex),
        .dst     (dst_ex),
        .tuse_rs (tuse_rs_ex),
        .tuse_rt (tuse_rt_ex),
        .tnew    (tnew_ex),
        .is_md   (is_md_ex),
        .is_mult (is_mult_ex),
        .is_div  (is_div_ex),
        .is_hilo (is_hilo_ex)
    );

    instr_class u_cls_mem (
        .ir      (IR_MEM),
        .rs      (rs_m),
        .rt      (rt_m),
        .dst     (dst_m),
        .tuse_rs (tuse_rs_m),
        .tuse_rt (tuse_rt_m),
        .tnew    (tnew_m),
        .is_md   (is_md_m),
        .is_mult (is_mult_m),
        .is_div  (is_div_m),
        .is_hilo (is_hilo_m)
    );

    // Only a subset of the later-stage classification feeds the hazard compare
    assign unused_fields = ^{dst_d, tnew_d, is_md_d, is_mult_d, is_div_d,
                             rs_ex, rt_ex, tuse_rs_ex, tuse_rt_ex, is_hilo_ex,
                             rs_m, rt_m, tuse_rs_m, tuse_rt_m,
                             is_md_m, is_mult_m, is_div_m, is_hilo_m};

    // One source against one producer: stall if the value will not be ready in time
    function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] dst, input logic [1:0] tnew);
        return (src != 5'd0) && (tuse != T_NONE) && (tnew != T_NONE) &&
               (src == dst) && (tuse < tnew);
    endfunction

    // Stall decision and derived enables, zero latency from the IR inputs
    always_comb begin
        tnew_mem   = t_age(tnew_m);
        data_stall = src_hazard(rs_d, tuse_rs_d, dst_ex, tnew_ex)  |
                     src_hazard(rt_d, tuse_rt_d, dst_ex, tnew_ex)  |
                     src_hazard(rs_d, tuse_rs_d, dst_m,  tnew_mem) |
                     src_hazard(rt_d, tuse_rt_d, dst_m,  tnew_mem);
        md_start   = is_md_ex;
        // While reset is held the counter is treated as already cleared
        md_busy    = (md_cnt_q != '0) && !reset;
        md_stall   = is_hilo_d && (md_start || md_busy);
        stall      = data_stall || md_stall;
        pc_en      = !stall;
        ifid_en    = !stall;
        idex_clr   = stall;
        stall_cnt  = stall_cnt_q;
    end

    // Next-state for the MD busy counter (reload wins over countdown) and the stall counter
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start)
            md_cnt_d = is_mult_ex ? MD_W'(MULT_CYCLES) : MD_W'(DIV_CYCLES);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - MD_W'(1);

        stall_cnt_d = stall_cnt_q;
        if (stall)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (reset) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed, table-driven checks of the hazard/stall controller.
module tb_hazard_stall_ctrl;
    import mips_defs::*;

    localparam int unsigned CNT_W = 3;

    logic             CLK = 1'b0;
    logic             reset;
    logic [31:0]      IR_D, IR_EX, IR_MEM;
    logic             pc_en, ifid_en, idex_clr, md_start, md_busy;
    logic [CNT_W-1:0] stall_cnt;

    int unsigned      checks = 0;
    int unsigned      errors = 0;
    logic [CNT_W-1:0] exp_cnt;

    hazard_stall_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .IR_D      (IR_D),
        .IR_EX     (IR_EX),
        .IR_MEM    (IR_MEM),
        .pc_en     (pc_en),
        .ifid_en   (ifid_en),
        .idex_clr  (idex_clr),
        .md_start  (md_start),
        .md_busy   (md_busy),
        .stall_cnt (stall_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    // Drive one cycle at negedge, check outputs mid-cycle, then track the expected counter
    task automatic cyc(input int step, input logic [31:0] d, input logic [31:0] ex,
                       input logic [31:0] mem, input logic rst, input logic e_stall,
                       input logic e_start, input logic e_busy);
        @(negedge CLK);
        IR_D   = d;
        IR_EX  = ex;
        IR_MEM = mem;
        reset  = rst;
        #2;
        chk("pc_en",     step, 32'(pc_en),     32'(!e_stall));
        chk("ifid_en",   step, 32'(ifid_en),   32'(!e_stall));
        chk("idex_clr",  step, 32'(idex_clr),  32'(e_stall));
        chk("md_start",  step, 32'(md_start),  32'(e_start));
        chk("md_busy",   step, 32'(md_busy),   32'(e_busy));
        chk("stall_cnt", step, 32'(stall_cnt), 32'(exp_cnt));
        if (rst)
            exp_cnt = '0;
        else if (e_stall)
            exp_cnt = exp_cnt + 1'b1;
    endtask

    typedef struct {
        logic [31:0] d;
        logic [31:0] ex;
        logic [31:0] mem;
        logic        stall;
    } vec_t;

    vec_t tbl[19];

    initial begin
        logic [31:0] lw8, lw_div_d, mflo4, mfhi4, mult12, div12;

        lw8    = i_ins(OP_LW, 5'd0, 5'd8, 16'd0);
        mflo4  = r_ins(5'd0, 5'd0, 5'd4, FN_MFLO);
        mfhi4  = r_ins(5'd0, 5'd0, 5'd4, FN_MFHI);
        mult12 = r_ins(5'd1, 5'd2, 5'd0, FN_MULT);
        div12  = r_ins(5'd1, 5'd2, 5'd0, FN_DIV);
        lw_div_d = r_ins(5'd8, 5'd1, 5'd9, FN_ADDU);

        //          IR_D                                  IR_EX                                 IR_MEM                               stall
        tbl[0]  = '{lw_div_d,                             lw8,                                  32'd0,                               1'b1};
        tbl[1]  = '{lw_div_d,                             32'd0,                                lw8,                                 1'b0};
        tbl[2]  = '{i_ins(OP_BEQ, 5'd3, 5'd0, 16'd4),    r_ins(5'd1, 5'd2, 5'd3, FN_ADDU),     32'd0,                               1'b1};
        tbl[3]  = '{i_ins(OP_BEQ, 5'd0, 5'd0, 16'd4),    r_ins(5'd1, 5'd2, 5'd0, FN_ADDU),     32'd0,                               1'b0};
        tbl[4]  = '{i_ins(OP_SW, 5'd6, 5'd5, 16'd4),     i_ins(OP_LW, 5'd0, 5'd5, 16'd0),      32'd0,                               1'b0};
        tbl[5]  = '{i_ins(OP_SW, 5'd6, 5'd5, 16'd4),     32'd0,                                i_ins(OP_LW, 5'd0, 5'd6, 16'd0),     1'b0};
        tbl[6]  = '{r_ins(5'd31, 5'd0, 5'd0, FN_JR),     {OP_JAL, 26'd16},                     32'd0,                               1'b0};
        tbl[7]  = '{r_ins(5'd31, 5'd0, 5'd0, FN_JR),     32'd0,                                i_ins(OP_LW, 5'd0, 5'd31, 16'd0),    1'b1};
        tbl[8]  = '{i_ins(OP_BEQ, 5'd4, 5'd7, 16'd2),    32'd0,                                i_ins(OP_LW, 5'd0, 5'd7, 16'd0),     1'b1};
        tbl[9]  = '{i_ins(OP_ORI, 5'd4, 5'd2, 16'd1),    i_ins(OP_LUI, 5'd0, 5'd4, 16'h1234),  32'd0,                               1'b0};
        tbl[10] = '{i_ins(OP_SW, 5'd3, 5'd6, 16'd0),     i_ins(OP_ORI, 5'd1, 5'd6, 16'd5),     32'd0,                               1'b0};
        tbl[11] = '{32'd0,                                lw8,                                  i_ins(OP_LW, 5'd0, 5'd9, 16'd0),     1'b0};
        tbl[12] = '{{6'b111111, 5'd8, 5'd8, 16'd0},       lw8,                                  32'd0,                               1'b0};
        tbl[13] = '{r_ins(5'd2, 5'd3, 5'd1, FN_ADDU),    {6'b110000, 5'd0, 5'd2, 16'd0},       32'd0,                               1'b0};
        tbl[14] = '{r_ins(5'd2, 5'd7, 5'd1, FN_SUBU),    r_ins(5'd0, 5'd0, 5'd7, FN_MFHI),     i_ins(OP_LW, 5'd0, 5'd2, 16'd0),     1'b0};
        tbl[15] = '{mflo4,                                32'd0,                                32'd0,                               1'b0};
        tbl[16] = '{r_ins(5'd0, 5'd0, 5'd1, FN_ADDU),    i_ins(OP_LW, 5'd0, 5'd0, 16'd0),      32'd0,                               1'b0};
        tbl[17] = '{i_ins(OP_LW, 5'd9, 5'd2, 16'd0),     i_ins(OP_LW, 5'd0, 5'd9, 16'd8),      32'd0,                               1'b1};
        tbl[18] = '{r_ins(5'd5, 5'd0, 5'd0, FN_MTHI),    i_ins(OP_LW, 5'd0, 5'd5, 16'd0),      32'd0,                               1'b1};

        // Reset state
        reset = 1'b1; IR_D = '0; IR_EX = '0; IR_MEM = '0;
        exp_cnt = '0;
        repeat (2) @(posedge CLK);
        cyc(0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Combinational hazard vectors
        for (int i = 0; i < 19; i++)
            cyc(100 + i, tbl[i].d, tbl[i].ex, tbl[i].mem, 1'b0, tbl[i].stall, 1'b0, 1'b0);

        // Multiply: mflo held in D for the start cycle plus five busy cycles
        cyc(200, mflo4, mult12, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++)
            cyc(200 + k, mflo4, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(206, mflo4, 32'd0, mult12, 1'b0, 1'b0, 1'b0, 1'b0);

        // Divide interrupted by reset at busy cycle 3
        cyc(300, 32'd0, div12, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(301, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(302, mfhi4, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(303, mfhi4, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(304, mfhi4, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_cnt_after_reset", 304, 32'(stall_cnt), 32'd0);

        // Stall counter: seven stalls then wrap at 3 bits
        for (int k = 0; k < 7; k++)
            cyc(400 + k, lw_div_d, lw8, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(407, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_cnt_seven", 407, 32'(stall_cnt), 32'd7);
        cyc(408, lw_div_d, lw8, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(409, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_cnt_wrap", 409, 32'(stall_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage MIPS core.
- Inspects the instructions held in the ID, EX and MEM pipeline registers and decides when the front end must freeze.
- Drives PC write-enable, IF/ID enable and the ID/EX `clr` input (bubble insertion).
- Tracks the multi-cycle multiply/divide unit with an internal busy counter and keeps a stall performance counter.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu leaves EX
- DIV_CYCLES, 10, busy cycles after div/divu leaves EX
- CNT_W, 32, width of stall performance counter

Ports:
- CLK  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high; clears all state
- IR_D  in  32  instruction in ID stage
- IR_EX  in  32  instruction in EX stage
- IR_MEM  in  32  instruction in MEM stage
- pc_en  out  1  PC write enable (= ~stall)
- ifid_en  out  1  IF/ID register enable (= ~stall)
- idex_clr  out  1  ID/EX clear, inserts NOP (= stall)
- md_start  out  1  pulse to MD unit: IR_EX is mult/multu/div/divu
- md_busy  out  1  MD counter non-zero
- stall_cnt  out  CNT_W  number of stalled cycles since reset

Behaviour:
- Reset values: md_cnt=0, stall_cnt=0, md_busy=0.
  - Outputs during reset are combinational from the inputs with md_cnt treated as 0.
- Per-instruction classification (sub-module, combinational):
  - rs=IR[25:21], rt=IR[20:16].
  - Tuse_rs: beq/jr=0; addu/subu/ori/lw/sw/mult family/mthi/mtlo=1; otherwise none.
  - Tuse_rt: beq=0; addu/subu/mult family=1; sw=2; otherwise none.
  - Destination: R-type ALU/mfhi/mflo → rd; ori/lui/lw → rt; jal → 31; otherwise 0.
  - Tnew at EX: lw=2, ALU/mfhi/mflo=1, jal=0, lui=1.
  - Tnew at MEM: lw=1, others 0.
- Data stall (combinational): assert when, for src in {rs, rt} with Tuse defined and src≠0, either:
  - src==dst(EX) and Tuse<Tnew_EX, or
  - src==dst(MEM) and Tuse<Tnew_MEM.
  - Register $0 never stalls.
- MD stall: IR_D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo AND (md_start OR md_busy).
- stall = data_stall OR md_stall. pc_en, ifid_en and idex_clr follow stall in the same cycle; zero latency.
- md_cnt, next-state priority:
  1. reset → 0
  2. md_start with mult/multu → MULT_CYCLES; with div/divu → DIV_CYCLES
  3. md_cnt≠0 → md_cnt−1
  4. otherwise hold
- md_start reloads even when md_cnt≠0. This cannot occur legally because of the MD stall, but the reload rule is defined anyway.
- md_busy = (md_cnt≠0), registered state.
- stall_cnt: increments by 1 on each non-reset cycle with stall=1; wraps modulo 2^CNT_W.
- IR=0 (NOP, also the value of a cleared register) classifies as no-src, no-dst: never stalls.
- Reset mid-MD-operation: counter cleared the next edge; no residual busy.
- Unknown opcodes: no-src, no-dst.

Decomposition:
- Shared package `mips_defs`:
  - opcode/funct constants (LW 6'b100011, SW 6'b101011, BEQ 6'b000100, ORI 6'b001101, LUI 6'b001111, JAL 6'b000011)
  - funct codes (ADDU, SUBU, JR 001000, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011)
  - T_NONE encoding for Tuse/Tnew
- Sub-module `instr_class`: combinational decode of one IR → rs, rt, dst, Tuse_rs, Tuse_rt, Tnew, is_md, is_mult, is_div. Instantiated three times (D, EX, MEM).
- Controller: compare logic, MD counter, stall counter.

Test Plan:
- Load-use: IR_EX=lw $8,0($0), IR_D=addu $9,$8,$1 → stall=1, pc_en=0, idex_clr=1. Next cycle IR_EX=0, IR_MEM=lw → stall=0.
- Branch after ALU: IR_EX=addu $3,$1,$2, IR_D=beq $3,$0 → stall=1. Same IR_D with $0 as the only source matched → stall=0.
- Store data: IR_EX=lw $5, IR_D=sw $5,4($6) → stall=0 (Tuse_rt 2 ≥ Tnew 2). IR_MEM=lw $6, IR_D=sw $5,4($6) → stall=0.
- Multiply: IR_EX=mult $1,$2 → md_start=1. Then md_busy=1 for 5 cycles. IR_D=mflo $4 is stalled on the md_start cycle plus all 5 busy cycles (6 stalls); released on the cycle md_busy returns 0.
- Divide plus reset: start div, assert reset at busy cycle 3 → next cycle md_busy=0, stall_cnt=0, and mfhi in D does not stall.
- Counter: 7 stall cycles with CNT_W=3 → stall_cnt reads 7. One more stall → wraps to 0.
